// File: rtl/fetch_unit_pkg.sv
// Fetch-unit shared types and constants.
// Reset PC, bubble word, FSM states, F/D bundle.
package fetch_unit_pkg;

   localparam logic [31:0] PC_RESET_DEF  = 32'h0000_3000;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

   typedef enum logic {
      S_FETCH = 1'b0,
      S_HOLD  = 1'b1
   } fu_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        valid;
   } fd_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port.
// Single outstanding read; rvalid may follow req in the same cycle.
interface fetch_unit_if;

   logic        req;
   logic [31:0] addr;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (
      output req,
      output addr,
      input  rvalid,
      input  rdata
   );

   modport slave (
      input  req,
      input  addr,
      output rvalid,
      output rdata
   );

endinterface

// File: rtl/fetch_unit_fd_reg.sv
// F/D pipeline register.
// Load on transfer, freeze on hold, otherwise a bubble.
module fd_reg
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic clk,
   input  logic reset_n,
   input  logic load,
   input  logic hold,
   input  fd_t  d,
   output fd_t  q
);

   localparam fd_t BUBBLE = '{pc: 32'h0, instr: NOP_INSTR, valid: 1'b0};

   // capture, freeze, or squash the decode slot
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q <= BUBBLE;
      end else if (load) begin
         q <= d;
      end else if (!hold) begin
         q <= BUBBLE;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Fetch-stage sequencer: owns F_PC, imem reads and the F/D register.
// A word that cannot transfer is parked in hold_buf until D accepts it.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] PC_RESET  = PC_RESET_DEF,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [31:0]        npc,
   input  logic               stall_D,
   input  logic               flush_D,
   fetch_unit_if.master       imem,
   output logic [31:0]        F_PC,
   output logic [31:0]        D_PC,
   output logic [31:0]        D_instr,
   output logic               D_valid,
   output logic               fetch_busy
);

   fu_state_t   state;
   logic [31:0] pc_q;
   logic [31:0] hold_buf;
   logic        in_fetch;
   logic        word_avail;
   logic [31:0] word;
   logic        transfer;
   fd_t         fd_d;
   fd_t         fd_q;

   // word availability and transfer decision
   always_comb begin
      in_fetch   = (state == S_FETCH);
      word_avail = (in_fetch & imem.rvalid) | ~in_fetch;
      word       = in_fetch ? imem.rdata : hold_buf;
      transfer   = word_avail & ~stall_D & ~flush_D;
      fd_d       = '{pc: pc_q, instr: word, valid: 1'b1};
   end

   assign imem.req   = in_fetch;
   assign imem.addr  = pc_q;
   assign fetch_busy = in_fetch & ~imem.rvalid;
   assign F_PC       = pc_q;

   // fetch FSM: advance PC on transfer, park the word otherwise
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_FETCH;
         pc_q     <= PC_RESET;
         hold_buf <= 32'h0;
      end else begin
         unique case (state)
            S_FETCH: begin
               if (transfer) begin
                  pc_q <= npc;
               end else if (imem.rvalid) begin
                  hold_buf <= imem.rdata;
                  state    <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (transfer) begin
                  pc_q  <= npc;
                  state <= S_FETCH;
               end
            end
            default: state <= S_FETCH;
         endcase
      end
   end

   fd_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_fd_reg (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (transfer),
      .hold    (stall_D & ~flush_D),
      .d       (fd_d),
      .q       (fd_q)
   );

   assign D_PC    = fd_q.pc;
   assign D_instr = fd_q.instr;
   assign D_valid = fd_q.valid;

endmodule
